// File: rtl/gsc_pkg.sv
// gsc_pkg: shared definitions for gate_stim_checker.
// Contents: the FSM state encoding, the stimulus vector width, the
// error-counter ceiling and a saturating-increment helper.
package gsc_pkg;

    localparam int unsigned VEC_W   = 2;
    localparam logic [3:0]  ERR_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } gsc_state_e;

    // The error count sticks at ERR_MAX instead of wrapping back to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] val);
        if (val == ERR_MAX) begin
            sat_inc = ERR_MAX;
        end else begin
            sat_inc = val + 4'd1;
        end
    endfunction

endpackage

// File: rtl/gsc_if.sv
// gsc_if: groups the run handshake, the gate stimulus/response pins
// and the result flags of gate_stim_checker.
//   master modport: the checker (drives a, b, busy, done, pass, err_count;
//                   samples start and c)
//   slave modport : the environment (drives start and c)
interface gsc_if;
    import gsc_pkg::*;

    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;

    modport master (
        input  start, c,
        output a, b, busy, done, pass, err_count
    );

    modport slave (
        output start, c,
        input  a, b, busy, done, pass, err_count
    );

endinterface

// File: rtl/gsc_hold_timer.sv
// gsc_hold_timer: counts the cycles for which one stimulus vector is held.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load_i    - restart the count at zero (takes priority over count_i)
//   count_i   - advance the count by one
//   tc_o      - high on the last cycle of a hold (count == HOLD_CYCLES-1)
module gsc_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic tc_o
);

    localparam logic [7:0] TC_VAL = 8'(HOLD_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: load wins over count; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = 8'd0;
        end else if (count_i) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/gate_stim_checker.sv
// gate_stim_checker: drives the full truth table of a 2-input OR gate
// (a,b = 00,01,10,11), holds each vector HOLD_CYCLES cycles, samples
// the gate output c on the last cycle of every hold and counts
// mismatches (saturating at 15). The sweep repeats NUM_PASSES times.
// Ports:
//   clk, rst - clock, synchronous active-high reset (wins over start)
//   bus_if   - gsc_if.master: start, c in; a, b, busy, done, pass,
//              err_count out
// Optional build macro GSC_STOP_ON_FAIL_EN: end the run on the first
// mismatch instead of completing every vector.
module gate_stim_checker
    import gsc_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned NUM_PASSES  = 1
) (
    input  logic  clk,
    input  logic  rst,
    gsc_if.master bus_if
);

    localparam logic [3:0]       LAST_PASS = 4'(NUM_PASSES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC  = 2'b11;

    gsc_state_e       state_q, state_d;
    logic [VEC_W-1:0] vec_q,   vec_d;
    logic [3:0]       pcnt_q,  pcnt_d;
    logic [3:0]       err_q,   err_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic load_s;
    logic count_s;
    logic tc_s;
    logic mismatch_s;
    logic final_s;
    logic end_run_s;

    gsc_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_s),
        .count_i (count_s),
        .tc_o    (tc_s)
    );

    assign mismatch_s = (bus_if.c != (vec_q[1] | vec_q[0]));
    assign final_s    = (vec_q == LAST_VEC) && (pcnt_q == LAST_PASS);

`ifdef GSC_STOP_ON_FAIL_EN
    assign end_run_s = final_s || mismatch_s;
`else
    assign end_run_s = final_s;
`endif

    // Next-state logic: start acceptance, vector sweep, mismatch counting.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        pcnt_d  = pcnt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        load_s  = 1'b0;
        count_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus_if.start) begin
                    state_d = ST_DRIVE;
                    vec_d   = 2'b00;
                    pcnt_d  = 4'd0;
                    err_d   = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    load_s  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRIVE: begin
                count_s = 1'b1;
                if (tc_s) begin
                    // Last cycle of the hold: sample c and move on.
                    load_s = 1'b1;
                    if (mismatch_s) begin
                        err_d = sat_inc(err_q);
                    end else begin
                        err_d = err_q;
                    end
                    if (end_run_s) begin
                        state_d = ST_DONE;
                        vec_d   = 2'b00;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (vec_q == LAST_VEC) begin
                        vec_d  = 2'b00;
                        pcnt_d = pcnt_q + 4'd1;
                    end else begin
                        vec_d = vec_q + 2'b01;
                    end
                end else begin
                    vec_d = vec_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = 2'b00;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'b00;
            pcnt_q  <= 4'd0;
            err_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus_if.a         = vec_q[1];
    assign bus_if.b         = vec_q[0];
    assign bus_if.busy      = busy_q;
    assign bus_if.done      = done_q;
    assign bus_if.err_count = err_q;
    assign bus_if.pass      = done_q && (err_q == 4'd0);

endmodule

// File: tb/tb_gate_stim_checker.sv
// Testbench for gate_stim_checker: two instances (HOLD=10/PASSES=1 and
// HOLD=1/PASSES=15), a modelled gate under test with selectable faults,
// a table of runs plus hand-written reset and start-held sequences.
module tb_gate_stim_checker;

    localparam int H0 = 10;
    localparam int P0 = 1;
    localparam int H1 = 1;
    localparam int P1 = 15;
    localparam int LIMIT = 200;

    // Gate models driven onto c.
    localparam int M_OR    = 0;
    localparam int M_SA0   = 1;
    localparam int M_SA1   = 2;
    localparam int M_NOR   = 3;
    localparam int M_AND   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode0 = M_OR;
    int   mode1 = M_OR;
    int   sel = 0;
    logic start_r = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    gsc_if if0 ();
    gsc_if if1 ();

    gate_stim_checker #(.HOLD_CYCLES(H0), .NUM_PASSES(P0)) u_dut0 (
        .clk    (clk),
        .rst    (rst),
        .bus_if (if0)
    );

    gate_stim_checker #(.HOLD_CYCLES(H1), .NUM_PASSES(P1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus_if (if1)
    );

    always #5 clk = ~clk;

    function automatic logic gate(input int m, input logic x, input logic y);
        case (m)
            M_OR:    gate = x | y;
            M_SA0:   gate = 1'b0;
            M_SA1:   gate = 1'b1;
            M_NOR:   gate = ~(x | y);
            M_AND:   gate = x & y;
            default: gate = x | y;
        endcase
    endfunction

    assign if0.c     = gate(mode0, if0.a, if0.b);
    assign if1.c     = gate(mode1, if1.a, if1.b);
    assign if0.start = (sel == 0) && start_r;
    assign if1.start = (sel == 1) && start_r;

    // Observed outputs of the selected instance.
    logic [1:0] m_vec;
    logic       m_busy, m_done, m_pass;
    logic [3:0] m_err;
    assign m_vec  = (sel == 0) ? {if0.a, if0.b} : {if1.a, if1.b};
    assign m_busy = (sel == 0) ? if0.busy : if1.busy;
    assign m_done = (sel == 0) ? if0.done : if1.done;
    assign m_pass = (sel == 0) ? if0.pass : if1.pass;
    assign m_err  = (sel == 0) ? if0.err_count : if1.err_count;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string name;
        int    dut;
        int    mode;
        int    exp_err;
        int    exp_lat;
    } run_t;

    // One full run: accept, follow the sweep, check results at done.
    task automatic do_run(input run_t r);
        int  lat;
        int  hold;
        bit  seq_ok;
        logic [3:0] err_at_done;
        sel  = r.dut;
        hold = (r.dut == 0) ? H0 : H1;
        if (r.dut == 0) mode0 = r.mode; else mode1 = r.mode;
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        check({r.name, ".acc_busy"}, int'(m_busy), 1);
        check({r.name, ".acc_done"}, int'(m_done), 0);
        check({r.name, ".acc_vec"},  int'(m_vec), 0);
        lat = -1;
        seq_ok = 1'b1;
        for (int k = 1; k <= LIMIT; k++) begin
            tick();
            if (m_done) begin
                lat = k;
                break;
            end
            if ((m_vec != 2'((k / hold) % 4)) || !m_busy) seq_ok = 1'b0;
        end
        check({r.name, ".latency"}, lat, r.exp_lat);
        check({r.name, ".sequence"}, int'(seq_ok), 1);
        check({r.name, ".err"}, int'(m_err), r.exp_err);
        check({r.name, ".pass"}, int'(m_pass), (r.exp_err == 0) ? 1 : 0);
        check({r.name, ".end_busy"}, int'(m_busy), 0);
        check({r.name, ".end_vec"}, int'(m_vec), 0);
        err_at_done = m_err;
        for (int k = 0; k < 3; k++) tick();
        check({r.name, ".hold_done"}, int'(m_done), 1);
        check({r.name, ".hold_err"}, int'(m_err), int'(err_at_done));
    endtask

    run_t runs[8];

    initial begin
`ifdef GSC_STOP_ON_FAIL_EN
        runs[0] = '{"or",      0, M_OR,  0, 40};
        runs[1] = '{"sa0",     0, M_SA0, 1, 20};
        runs[2] = '{"sa1",     0, M_SA1, 1, 10};
        runs[3] = '{"nor",     0, M_NOR, 1, 10};
        runs[4] = '{"and",     0, M_AND, 1, 20};
        runs[5] = '{"h1_sa1",  1, M_SA1, 1, 1};
        runs[6] = '{"h1_nor",  1, M_NOR, 1, 1};
        runs[7] = '{"h1_or",   1, M_OR,  0, 60};
`else
        runs[0] = '{"or",      0, M_OR,  0, 40};
        runs[1] = '{"sa0",     0, M_SA0, 3, 40};
        runs[2] = '{"sa1",     0, M_SA1, 1, 40};
        runs[3] = '{"nor",     0, M_NOR, 4, 40};
        runs[4] = '{"and",     0, M_AND, 2, 40};
        runs[5] = '{"h1_sa1",  1, M_SA1, 15, 60};
        runs[6] = '{"h1_nor",  1, M_NOR, 15, 60};
        runs[7] = '{"h1_or",   1, M_OR,  0, 60};
`endif

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            sel = d;
            check("rst.vec",  int'(m_vec), 0);
            check("rst.busy", int'(m_busy), 0);
            check("rst.done", int'(m_done), 0);
            check("rst.pass", int'(m_pass), 0);
            check("rst.err",  int'(m_err), 0);
        end

        foreach (runs[i]) do_run(runs[i]);

        // Reset in the middle of a run (NOR gate so err_count is non-zero).
        sel = 0;
        mode0 = M_NOR;
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        for (int k = 1; k < 15; k++) tick();
`ifndef GSC_STOP_ON_FAIL_EN
        check("mid.busy_before", int'(m_busy), 1);
        check("mid.err_before", int'(m_err), 1);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid.vec",  int'(m_vec), 0);
        check("mid.busy", int'(m_busy), 0);
        check("mid.done", int'(m_done), 0);
        check("mid.pass", int'(m_pass), 0);
        check("mid.err",  int'(m_err), 0);
        tick();
        check("mid.idle_busy", int'(m_busy), 0);
        do_run('{"after_rst", 0, M_OR, 0, 40});

        // Start held high for a whole run: no restart, re-accept after done.
        sel = 0;
        mode0 = M_SA0;
        start_r = 1'b1;
        tick();
        begin
            int lat;
            lat = -1;
            for (int k = 1; k <= LIMIT; k++) begin
                tick();
                if (m_done) begin
                    lat = k;
                    break;
                end
            end
`ifdef GSC_STOP_ON_FAIL_EN
            check("held.latency", lat, 20);
            check("held.err", int'(m_err), 1);
`else
            check("held.latency", lat, 40);
            check("held.err", int'(m_err), 3);
`endif
        end
        tick();
        check("held.reacc_done", int'(m_done), 0);
        check("held.reacc_err",  int'(m_err), 0);
        check("held.reacc_busy", int'(m_busy), 1);
        start_r = 1'b0;

        // rst and start on the same edge: rst wins.
        rst = 1'b1;
        start_r = 1'b1;
        tick();
        check("prio.busy", int'(m_busy), 0);
        check("prio.done", int'(m_done), 0);
        rst = 1'b0;
        start_r = 1'b0;
        tick();
        check("prio.idle", int'(m_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gate_stim_checker.md
GATE_STIM_CHECKER -- requirements
Module: gate_stim_checker

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10, cycles each input vector is held (legal range 1..255).
REQ-002 SHALL have parameter NUM_PASSES, default 1, full truth-table sweeps per run (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request a run; sampled only in IDLE.
REQ-006 SHALL have port a  output  1  stimulus bit a to the 2-input OR gate under test.
REQ-007 SHALL have port b  output  1  stimulus bit b to the gate under test.
REQ-008 SHALL have port c  input  1  gate-under-test output, compared against a|b.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  high from run end until the next accepted start or rst.
REQ-011 SHALL have port pass  output  1  equals done AND err_count==0.
REQ-012 SHALL have port err_count  output  4  mismatches in the current or last run, saturating at 15.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, DONE; DONE behaves as IDLE for start acceptance.
REQ-014 SHALL accept start when in IDLE or DONE: on that edge a,b=0,0, busy=1, done=0, err_count=0, hold counter=0, state=DRIVE.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL sweep vectors in order {a,b}=00,01,10,11 per pass, repeating NUM_PASSES times.
REQ-017 SHALL hold each vector for exactly HOLD_CYCLES clock cycles.
REQ-018 SHALL sample c on the last cycle of each hold; if c != (a|b), SHALL increment err_count by 1 on that edge, saturating at 15.
REQ-019 SHALL, on the same edge as the sample, apply the next vector, with 11 wrapping to 00 when passes remain.
REQ-020 SHALL, on the sample edge of the last vector of the last pass, set busy=0, done=1, state=DONE, and return a,b to 0,0.
REQ-021 SHALL make run latency from start-accept edge to done-rise edge exactly 4*HOLD_CYCLES*NUM_PASSES cycles.
REQ-022 SHALL, for HOLD_CYCLES=1, change the vector on every edge and sample c every cycle.
REQ-023 SHALL hold err_count, pass, and done stable in DONE until the next accepted start or rst.

Reset
REQ-024 SHALL, when rst=1 at an edge (including mid-run), force state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, and clear all counters.
REQ-025 SHALL give rst priority over start on the same edge.

Configuration
REQ-026 SHALL, with macro GSC_STOP_ON_FAIL_EN defined, end the run on the first mismatch edge: err_count=1, done=1, pass=0, busy=0, a,b=0,0.
REQ-027 SHALL, without GSC_STOP_ON_FAIL_EN, always complete all vectors of all passes regardless of mismatches.

Structure
REQ-028 SHALL place the state enum, the vector width (2), and the ERR_MAX constant (15) in shared package gsc_pkg.
REQ-029 SHALL implement the hold counter as sub-module gsc_hold_timer (load, count, terminal-count output).

Verification
REQ-030 SHALL verify a correct OR gate, HOLD=10, PASSES=1: pulse start -> a,b = 00,01,10,11 each for 10 cycles; done at cycle 40; err_count=0; pass=1.
REQ-031 SHALL verify c stuck-at-0: -> err_count=3; pass=0. With GSC_STOP_ON_FAIL_EN: done at cycle 20, err_count=1.
REQ-032 SHALL verify c stuck-at-1, PASSES=15, HOLD=1: -> 15 mismatches; err_count=15 (saturation reached, no overflow wrap); done at cycle 60.
REQ-033 SHALL verify rst asserted at cycle 15 of a run: -> next edge all outputs 0, state IDLE; a subsequent start runs a full clean sweep.
REQ-034 SHALL verify start held high throughout a run: -> no restart mid-run; a new run is accepted on the edge after done rises, clearing err_count and done.
